// File: rtl/iim_reg_pkg.sv
// IIM-42652 register controller: shared constants, state encoding
// and the SPI frame helper.
package iim_reg_pkg;

  localparam logic [6:0] REG_DEVICE_CONFIG = 7'h11;
  localparam logic [6:0] REG_WHO_AM_I      = 7'h75;
  localparam logic [6:0] REG_PWR_MGMT0     = 7'h4E;
  localparam logic [6:0] REG_GYRO_CONFIG0  = 7'h4F;
  localparam logic [6:0] REG_ACCEL_CONFIG0 = 7'h50;
  localparam logic [6:0] REG_ACCEL_DATA_X1 = 7'h1F;

  localparam logic [7:0] WHO_AM_I_VAL   = 8'h6F;
  localparam logic [7:0] SOFT_RESET_VAL = 8'h01;
  localparam logic [7:0] PWR_MGMT0_VAL  = 8'h0F;

  localparam int BURST_LEN = 12;

  typedef enum logic [3:0] {
    ST_PWRUP     = 4'd0,
    ST_RST_ISSUE = 4'd1,
    ST_RST_WAIT  = 4'd2,
    ST_RSTDLY    = 4'd3,
    ST_ID_ISSUE  = 4'd4,
    ST_ID_WAIT   = 4'd5,
    ST_CFG_ISSUE = 4'd6,
    ST_CFG_WAIT  = 4'd7,
    ST_PWRON     = 4'd8,
    ST_RUN       = 4'd9,
    ST_RD_ISSUE  = 4'd10,
    ST_RD_WAIT   = 4'd11,
    ST_ERR       = 4'd12
  } state_t;

  function automatic logic [15:0] spi_frame(
    input logic       rw,
    input logic [6:0] addr,
    input logic [7:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/iim_sample_timer.sv
// Free-running sample tick generator; held at zero while disabled
// so every enable starts a full period.
module iim_sample_timer #(
  parameter int unsigned DIV = 10000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt;
  logic         wrap;

  assign wrap   = cnt == W'(DIV - 1);
  assign o_tick = i_en & wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  cnt <= '0;
    else if (!i_en) cnt <= '0;
    else if (wrap)  cnt <= '0;
    else            cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/iim_reg_ctrl.sv
// IIM-42652 register controller: init/ID check, then periodic
// 12-byte data bursts assembled into one 6-axis sample.
module iim_reg_ctrl
  import iim_reg_pkg::*;
#(
  parameter int unsigned PWRUP_DLY_CYC = 20000,
  parameter int unsigned RST_DLY_CYC   = 2000,
  parameter int unsigned PWRON_DLY_CYC = 50000,
  parameter int unsigned SAMPLE_DIV    = 10000,
  parameter logic [7:0]  GYRO_CFG      = 8'h06,
  parameter logic [7:0]  ACCEL_CFG     = 8'h06,
  parameter int unsigned ID_RETRY      = 3,
  parameter int unsigned ACK_TIMEOUT   = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_spi_wr_req,
  output logic [15:0] o_spi_wdata,
  input  logic        i_spicom_ready,
  input  logic        i_spi_wr_ack,
  input  logic        i_spi_rdata_valid,
  input  logic [7:0]  i_spi_rdata,
  output logic        o_init_done,
  output logic        o_id_err,
  output logic        o_timeout,
  output logic        o_overrun,
  output logic        o_imu_valid,
  output logic [15:0] o_accel_x,
  output logic [15:0] o_accel_y,
  output logic [15:0] o_accel_z,
  output logic [15:0] o_gyro_x,
  output logic [15:0] o_gyro_y,
  output logic [15:0] o_gyro_z
);

  state_t       state_q, state_n;
  logic [31:0]  cnt_q, cnt_n;
  logic [3:0]   idx_q, idx_n;
  logic [7:0]   retry_q, retry_n;
  logic [7:0]   rbyte_q, rbyte_n;
  logic [95:0]  shadow_q, shadow_n;
  logic [95:0]  sample_q, sample_n;
  logic [15:0]  wdata_q, wdata_n;
  logic         req_q, req_n;
  logic         init_q, init_n;
  logic         iderr_q, iderr_n;
  logic         to_q, to_n;
  logic         ovr_q, ovr_n;
  logic         vld_q, vld_n;
  logic         tick, in_wait, busy, last_rd;
  logic [15:0]  cfg_frame;

  iim_sample_timer #(.DIV(SAMPLE_DIV)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (init_q),
    .o_tick  (tick)
  );

  assign in_wait = (state_q == ST_RST_WAIT) || (state_q == ST_ID_WAIT)
                || (state_q == ST_CFG_WAIT) || (state_q == ST_RD_WAIT);
  assign busy    = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT);
  assign last_rd = idx_q == 4'(BURST_LEN - 1);

  always_comb begin
    cfg_frame = spi_frame(1'b0, REG_PWR_MGMT0, PWR_MGMT0_VAL);
    unique case (1'b1)
      (idx_q == 4'd0): cfg_frame = spi_frame(1'b0, REG_GYRO_CONFIG0, GYRO_CFG);
      (idx_q == 4'd1): cfg_frame = spi_frame(1'b0, REG_ACCEL_CONFIG0, ACCEL_CFG);
      default: ;
    endcase
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    retry_n  = retry_q;
    rbyte_n  = rbyte_q;
    shadow_n = shadow_q;
    sample_n = sample_q;
    wdata_n  = wdata_q;
    req_n    = 1'b0;
    init_n   = init_q;
    iderr_n  = iderr_q;
    to_n     = to_q;
    ovr_n    = 1'b0;
    vld_n    = 1'b0;
    if (in_wait) cnt_n = i_spi_wr_ack ? '0 : cnt_q + 32'd1;
    if (in_wait && i_spi_rdata_valid) rbyte_n = i_spi_rdata;
    unique case (state_q)
      ST_PWRUP: begin
        cnt_n = cnt_q + 32'd1;
        if (cnt_q == 32'(PWRUP_DLY_CYC - 1)) begin
          cnt_n   = '0;
          state_n = ST_RST_ISSUE;
        end
      end
      ST_RST_ISSUE: if (i_spicom_ready) begin
        req_n   = 1'b1;
        wdata_n = spi_frame(1'b0, REG_DEVICE_CONFIG, SOFT_RESET_VAL);
        cnt_n   = '0;
        state_n = ST_RST_WAIT;
      end
      ST_RST_WAIT: if (i_spi_wr_ack) state_n = ST_RSTDLY;
      ST_RSTDLY: begin
        cnt_n = cnt_q + 32'd1;
        if (cnt_q == 32'(RST_DLY_CYC - 1)) begin
          cnt_n   = '0;
          retry_n = '0;
          state_n = ST_ID_ISSUE;
        end
      end
      ST_ID_ISSUE: if (i_spicom_ready) begin
        req_n   = 1'b1;
        wdata_n = spi_frame(1'b1, REG_WHO_AM_I, 8'h00);
        cnt_n   = '0;
        state_n = ST_ID_WAIT;
      end
      ST_ID_WAIT: if (i_spi_wr_ack) begin
        if (rbyte_q == WHO_AM_I_VAL) begin
          idx_n   = '0;
          state_n = ST_CFG_ISSUE;
        end else if (retry_q == 8'(ID_RETRY - 1)) begin
          iderr_n = 1'b1;
          state_n = ST_ERR;
        end else begin
          retry_n = retry_q + 8'd1;
          state_n = ST_ID_ISSUE;
        end
      end
      ST_CFG_ISSUE: if (i_spicom_ready) begin
        req_n   = 1'b1;
        wdata_n = cfg_frame;
        cnt_n   = '0;
        state_n = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: if (i_spi_wr_ack) begin
        idx_n   = idx_q + 4'd1;
        state_n = ST_CFG_ISSUE;
        if (idx_q == 4'd2) begin
          idx_n   = '0;
          state_n = ST_PWRON;
        end
      end
      ST_PWRON: begin
        cnt_n = cnt_q + 32'd1;
        if (cnt_q == 32'(PWRON_DLY_CYC - 1)) begin
          cnt_n   = '0;
          init_n  = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: if (tick) begin
        idx_n   = '0;
        state_n = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: if (i_spicom_ready) begin
        req_n   = 1'b1;
        wdata_n = spi_frame(1'b1, REG_ACCEL_DATA_X1 + {3'b000, idx_q}, 8'h00);
        cnt_n   = '0;
        state_n = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (i_spi_wr_ack) begin
        idx_n   = idx_q + 4'd1;
        state_n = ST_RD_ISSUE;
        if (last_rd) begin
          idx_n    = '0;
          sample_n = shadow_q;
          vld_n    = 1'b1;
          state_n  = tick ? ST_RD_ISSUE : ST_RUN;
        end
      end
      ST_ERR: ;
      default: state_n = ST_PWRUP;
    endcase
    // Byte idx lands big-endian: byte 0 is the top of the shadow.
    for (int i = 0; i < BURST_LEN; i++) begin
      if (state_q == ST_RD_WAIT && i_spi_rdata_valid && idx_q == 4'(i))
        shadow_n[8*(BURST_LEN-1-i) +: 8] = i_spi_rdata;
    end
    if (tick && busy && !(state_q == ST_RD_WAIT && i_spi_wr_ack && last_rd))
      ovr_n = 1'b1;
    if (in_wait && !i_spi_wr_ack && cnt_q == 32'(ACK_TIMEOUT - 1)) begin
      cnt_n   = '0;
      idx_n   = '0;
      to_n    = 1'b1;
      init_n  = 1'b0;
      state_n = ST_PWRUP;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_PWRUP;
      cnt_q    <= '0;
      idx_q    <= '0;
      retry_q  <= '0;
      rbyte_q  <= '0;
      shadow_q <= '0;
      sample_q <= '0;
      wdata_q  <= '0;
      req_q    <= 1'b0;
      init_q   <= 1'b0;
      iderr_q  <= 1'b0;
      to_q     <= 1'b0;
      ovr_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      retry_q  <= retry_n;
      rbyte_q  <= rbyte_n;
      shadow_q <= shadow_n;
      sample_q <= sample_n;
      wdata_q  <= wdata_n;
      req_q    <= req_n;
      init_q   <= init_n;
      iderr_q  <= iderr_n;
      to_q     <= to_n;
      ovr_q    <= ovr_n;
      vld_q    <= vld_n;
    end
  end

  assign o_spi_wr_req = req_q;
  assign o_spi_wdata  = wdata_q;
  assign o_init_done  = init_q;
  assign o_id_err     = iderr_q;
  assign o_timeout    = to_q;
  assign o_overrun    = ovr_q;
  assign o_imu_valid  = vld_q;
  assign o_accel_x    = sample_q[95:80];
  assign o_accel_y    = sample_q[79:64];
  assign o_accel_z    = sample_q[63:48];
  assign o_gyro_x     = sample_q[47:32];
  assign o_gyro_y     = sample_q[31:16];
  assign o_gyro_z     = sample_q[15:0];

endmodule

// File: tb/tb_iim_reg_ctrl.sv
// Scoreboard bench for iim_reg_ctrl with a behavioural SPI
// master + IMU slave model.
module tb_iim_reg_ctrl;

  localparam int PWRUP = 20;
  localparam int RSTD  = 10;
  localparam int PWRON = 50;
  localparam int DIV   = 300;
  localparam int TOUT  = 4096;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [15:0] wdata;
  logic        ready;
  logic        ack;
  logic        rv;
  logic [7:0]  rdata;
  logic        init_done, id_err, tmo, ovr, vld;
  logic [15:0] ax, ay, az, gx, gy, gz;

  iim_reg_ctrl #(
    .PWRUP_DLY_CYC (PWRUP),
    .RST_DLY_CYC   (RSTD),
    .PWRON_DLY_CYC (PWRON),
    .SAMPLE_DIV    (DIV),
    .GYRO_CFG      (8'h06),
    .ACCEL_CFG     (8'h06),
    .ID_RETRY      (3),
    .ACK_TIMEOUT   (TOUT)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .o_spi_wr_req      (req),
    .o_spi_wdata       (wdata),
    .i_spicom_ready    (ready),
    .i_spi_wr_ack      (ack),
    .i_spi_rdata_valid (rv),
    .i_spi_rdata       (rdata),
    .o_init_done       (init_done),
    .o_id_err          (id_err),
    .o_timeout         (tmo),
    .o_overrun         (ovr),
    .o_imu_valid       (vld),
    .o_accel_x         (ax),
    .o_accel_y         (ay),
    .o_accel_z         (az),
    .o_gyro_x          (gx),
    .o_gyro_y          (gy),
    .o_gyro_z          (gz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [15:0] frame_q[$];
  logic [95:0] samp_q[$];
  int nreq = 0, nsamp = 0, novr = 0;
  int last_req_cyc = 0, last_ack_cyc = 0;

  logic [7:0] mem [0:127];
  logic [7:0] id_val = 8'h6F;
  int lat = 4;
  bit hold_burst = 0;

  task automatic check(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_init(input logic [7:0] id);
    frame_q.push_back(16'h1101);
    frame_q.push_back(16'hF500);
    if (id == 8'h6F) begin
      frame_q.push_back(16'h4F06);
      frame_q.push_back(16'h5006);
      frame_q.push_back(16'h4E0F);
    end else begin
      frame_q.push_back(16'hF500);
      frame_q.push_back(16'hF500);
    end
  endtask

  task automatic push_burst(input logic [7:0] base, input int nrd);
    logic [95:0] s;
    s = '0;
    for (int i = 0; i < 12; i++) begin
      if (i < nrd) frame_q.push_back({8'h9F + 8'(i), 8'h00});
      s[95-8*i -: 8] = base + 8'(i);
    end
    if (nrd == 12) samp_q.push_back(s);
  endtask

  task automatic load_mem(input logic [7:0] base);
    for (int i = 0; i < 12; i++) mem[31+i] = base + 8'(i);
  endtask

  task automatic wait_samples(input int n, input int lim);
    for (int t = 0; t < lim && nsamp < n; t++) begin
      @(posedge clk); #2;
    end
    check("sample_count", 96'(nsamp >= n), 96'd1);
  endtask

  task automatic wait_init(input int lim);
    for (int t = 0; t < lim && !init_done; t++) begin
      @(posedge clk); #1;
    end
    check("init_done_rise", 96'(init_done), 96'd1);
  endtask

  task automatic wait_req(input int n, input int lim);
    for (int t = 0; t < lim && nreq < n; t++) begin
      @(posedge clk); #1;
    end
    check("req_seen", 96'(nreq >= n), 96'd1);
  endtask

  // Frame scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n && req) begin
      nreq++;
      last_req_cyc = cyc;
      if (frame_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %0h expected none", wdata);
      end else begin
        check("frame", 96'(wdata), 96'(frame_q.pop_front()));
      end
    end
  end

  // Sample scoreboard
  initial begin
    bit chk_low;
    chk_low = 0;
    forever begin
      @(negedge clk);
      if (chk_low) begin
        check("valid_one_cycle", 96'(vld), 96'd0);
        chk_low = 0;
      end
      if (ovr) novr++;
      if (rst_n && vld) begin
        nsamp++;
        chk_low = 1;
        check("burst_complete", 96'(frame_q.size()), 96'd0);
        if (samp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0h expected none",
                   {ax, ay, az, gx, gy, gz});
        end else begin
          check("sample", {ax, ay, az, gx, gy, gz}, samp_q.pop_front());
        end
      end
    end
  end

  // SPI master + IMU slave model
  initial begin
    int ph, cnt;
    bit armed;
    logic [15:0] cur;
    ph = 0; cnt = 0; armed = 0; cur = '0;
    ready = 1'b1; ack = 1'b0; rv = 1'b0; rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      ack = 1'b0;
      rv  = 1'b0;
      if (!rst_n) begin
        ph = 0;
        armed = 0;
        ready = 1'b1;
      end else begin
        if (ph != 0 && req) begin
          checks++;
          errors++;
          $display("FAIL req_while_busy: got req=1 expected 0");
        end
        case (ph)
          0: if (req) begin
            cur = wdata;
            ready = 1'b0;
            cnt = lat;
            ph = 1;
            if (hold_burst && cur[14:8] == 7'h1F) begin
              armed = 1;
              hold_burst = 0;
            end
          end
          1: begin
            cnt--;
            if (cnt == 0) begin
              if (cur[15]) begin
                rdata = (cur[14:8] == 7'h75) ? id_val : mem[cur[14:8]];
                rv = 1'b1;
              end
              ph = 2;
            end
          end
          2: if (armed && cur[14:8] == 7'h23) begin
            if (tmo) begin
              armed = 0;
              ready = 1'b1;
              ph = 0;
            end
          end else begin
            ack = 1'b1;
            last_ack_cyc = cyc;
            ph = 3;
          end
          3: ph = 4;
          default: begin
            ready = 1'b1;
            ph = 0;
          end
        endcase
      end
    end
  end

  initial begin
    int rel, n0;
    rst_n = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    load_mem(8'h01);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 96'(req), 96'd0);
    check("rst_wdata", 96'(wdata), 96'd0);
    check("rst_flags", 96'({init_done, id_err, tmo, ovr, vld}), 96'd0);
    check("rst_sample", {ax, ay, az, gx, gy, gz}, 96'd0);

    push_init(8'h6F);
    push_burst(8'h01, 12);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rel = cyc;
    wait_req(1, 200);
    check("pwrup_delay", 96'(last_req_cyc - rel), 96'(PWRUP + 1));
    wait_init(2000);
    check("pwron_delay", 96'(cyc - last_ack_cyc), 96'(PWRON + 1));
    check("init_frames_used", 96'(frame_q.size()), 96'd12);

    wait_samples(1, 1000);
    check("accel_x", 96'(ax), 96'h0102);
    check("accel_z", 96'(az), 96'h0506);
    check("gyro_z", 96'(gz), 96'h0B0C);
    push_burst(8'h01, 12);
    wait_samples(2, 1000);
    check("no_overrun_fast", 96'(novr), 96'd0);

    lat = 30;
    push_burst(8'h01, 12);
    wait_samples(3, 3000);
    push_burst(8'h01, 12);
    wait_samples(4, 3000);
    check("overrun_seen", 96'(novr > 0), 96'd1);

    lat = 4;
    hold_burst = 1;
    push_burst(8'h01, 5);
    for (int t = 0; t < TOUT + 2000 && !tmo; t++) begin
      @(posedge clk); #1;
    end
    check("timeout_flag", 96'(tmo), 96'd1);
    check("timeout_clr_init", 96'(init_done), 96'd0);
    check("timeout_frames", 96'(frame_q.size()), 96'd0);
    check("timeout_keep", {ax, ay, az, gx, gy, gz},
          96'h0102_0304_0506_0708_090A_0B0C);
    push_init(8'h6F);
    load_mem(8'hF0);
    push_burst(8'hF0, 12);
    wait_init(2000);
    check("reinit_frames", 96'(frame_q.size()), 96'd12);
    wait_samples(5, 1000);
    check("gyro_x_neg", 96'(gx), 96'hF6F7);
    check("timeout_sticky", 96'(tmo), 96'd1);

    push_burst(8'hF0, 12);
    for (int t = 0; t < 1000 && frame_q.size() > 6; t++) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flags",
          96'({req, init_done, id_err, tmo, ovr, vld}), 96'd0);
    check("arst_wdata", 96'(wdata), 96'd0);
    check("arst_sample", {ax, ay, az, gx, gy, gz}, 96'd0);
    frame_q.delete();
    samp_q.delete();
    id_val = 8'h00;
    push_init(8'h00);
    repeat (3) @(posedge clk);
    #1;
    n0 = nreq;
    rst_n = 1'b1;
    rel = cyc;
    wait_req(n0 + 1, 200);
    check("pwrup_restart", 96'(last_req_cyc - rel), 96'(PWRUP + 1));
    for (int t = 0; t < 2000 && !id_err; t++) begin
      @(posedge clk); #1;
    end
    check("id_err_flag", 96'(id_err), 96'd1);
    check("id_err_no_init", 96'(init_done), 96'd0);
    check("id_err_reads", 96'(frame_q.size()), 96'd0);
    n0 = nreq;
    repeat (10000) @(posedge clk);
    #1;
    check("id_err_silent", 96'(nreq - n0), 96'd0);
    check("id_err_sticky", 96'(id_err), 96'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
